dmem_agu: RTL
=============

# dmem_agu

Circular-buffer address generation unit sitting directly upstream of `datamem`. It accepts 16-bit samples over a valid/ready handshake and writes each sample into a modulo-addressed delay line in data memory. It then sweeps the delay line newest-to-oldest and hands each stored value, with its tap index, to the downstream MAC stage. It owns `datamem`'s `en`/`addr`/`in` ports exclusively and consumes its `out` port.

## Interface
- `BUF_BASE`, 8'h00: first data-memory address of the delay line.
- `BUF_LEN`, 16: delay-line length / tap count; legal range 2..256; `BUF_BASE+BUF_LEN` must not exceed 256.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: upstream sample valid.
- `s_data` in 16: upstream sample.
- `s_ready` out 1: `(state==IDLE)`, combinational from state.
- `mem_en` out 1: datamem write enable, registered.
- `mem_addr` out 8: datamem address, registered.
- `mem_din` out 16: datamem write data, registered.
- `mem_dout` in 16: datamem read data; asynchronous read, valid in the same cycle `mem_addr` is driven.
- `tap_valid` out 1: tap output valid.
- `tap_data` out 16: stored value for the tap.
- `tap_idx` out 8: tap index, 0 = newest sample.
- `tap_last` out 1: high with `tap_valid` when `tap_idx==BUF_LEN-1`.
- `tap_ready` in 1: downstream accepts the tap.
- `busy` out 1: `state!=IDLE`.

## Operation
- States: CLEAR (only with the macro), IDLE, WR, RD, OUT.
- Internal write pointer `wptr` runs 0..BUF_LEN-1 and wraps to 0.
- Internal tap counter `k` runs 0..BUF_LEN-1.
- **IDLE:** `s_ready`=1. On `s_valid&&s_ready`:
  - latch `s_data` into `mem_din`;
  - set `mem_addr=BUF_BASE+wptr`, `mem_en`=1;
  - go to WR.
- **WR:** one cycle; datamem writes at the closing edge. At that edge:
  - set `newest=wptr`, `k`=0;
  - advance `wptr` (wrap BUF_LEN-1→0);
  - set `mem_en`=0 and `mem_addr=BUF_BASE+newest`;
  - go to RD.
- **RD:** capture `mem_dout` into `tap_data`, set `tap_idx=k`, `tap_last=(k==BUF_LEN-1)`, `tap_valid`=1; go to OUT.
- **OUT:** hold `tap_valid`, `tap_data`, `tap_idx`, `tap_last` and `mem_addr` stable while `tap_ready`=0. On `tap_ready`:
  - clear `tap_valid` and `tap_last`;
  - if `tap_last`, go to IDLE;
  - otherwise set `k=k+1`, `mem_addr=BUF_BASE+((newest-k-1) mod BUF_LEN)`, and go to RD.
- Modulo arithmetic is 9-bit: subtract, then add `BUF_LEN` if negative. No carry out of the buffer region.
- `s_valid` outside IDLE is ignored (`s_ready`=0); upstream holds its data.
- `mem_en` is never high in RD or OUT.
- Reset values: state CLEAR (with macro) or IDLE, `wptr`=0, `k`=0, `mem_en`=0, `mem_addr=BUF_BASE`, `mem_din`=0, `tap_valid`=0, `tap_data`=0, `tap_idx`=0, `tap_last`=0.
- Reset mid-operation: all state and outputs return to reset values immediately. Memory contents are untouched; the partial sweep is abandoned.

## Timing
- T0 = handshake edge. T1: `mem_en`=1. T2: RD. T3: first `tap_valid`.
- Tap k is first valid at T3+2k when `tap_ready` is held high.
- Full sample cycle: 1 + 2·BUF_LEN cycles. `s_ready` rises in the cycle after the last tap is accepted.
- Back-to-back samples: the earliest next handshake is that same cycle.

## Configuration
- `DMEM_AGU_CLEAR_EN` defined:
  - reset enters CLEAR;
  - CLEAR writes 16'h0000 to `BUF_BASE..BUF_BASE+BUF_LEN-1`, one address per cycle with `mem_en`=1 (BUF_LEN cycles), then enters IDLE;
  - `s_ready`=0 and `busy`=1 throughout CLEAR.
- Not defined:
  - reset enters IDLE directly;
  - the delay line holds whatever was preloaded (e.g. `$readmemb`).

## Test plan
- BUF_BASE=0, BUF_LEN=4, no macro, memory preloaded 1,2,3,4; push 16'h00AA. Required: T1 `mem_en`=1, addr 0, din 00AA; taps idx0..3 = 00AA, 4, 3, 2 from addrs 0, 3, 2, 1; `tap_last` only on idx3.
- Push 1,2,3,4,5 with `tap_ready`=1. Required: fifth write goes to addr 0 (wrap); its taps are 5,4,3,2; each sweep lasts 9 cycles.
- Hold `tap_ready`=0 for 5 cycles at idx1. Required: `tap_data`/`tap_idx`/`mem_addr` stable, `mem_en`=0; idx2 valid 2 cycles after `tap_ready` rises.
- Hold `s_valid`=1 with 16'h0077 through a sweep. Required: `s_ready`=0 until IDLE; sample accepted exactly once; exactly one `mem_en` pulse.
- Drop `rst_n` during OUT at idx2. Required: `tap_valid`=0, `mem_en`=0, `mem_addr`=BUF_BASE immediately; the next push writes addr 0.
- `DMEM_AGU_CLEAR_EN`, BUF_BASE=8'h10, BUF_LEN=4. Required: after reset, 4 writes of 0 to 10..13 with `s_ready`=0; then pushing 16'h0009 gives taps 9,0,0,0.

Source files
------------

// File: rtl/dmem_agu_if.sv
// dmem_agu_if: sample, datamem and tap signals between dmem_agu and its neighbours.
interface dmem_agu_if;
  logic s_valid;
  logic [15:0] s_data;
  logic s_ready;
  logic mem_en;
  logic [7:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic tap_valid;
  logic [15:0] tap_data;
  logic [7:0] tap_idx;
  logic tap_last;
  logic tap_ready;
  logic busy;
  modport slave (
    input s_valid, s_data, mem_dout, tap_ready,
    output s_ready, mem_en, mem_addr, mem_din, tap_valid, tap_data, tap_idx, tap_last, busy
  );
  modport master (
    output s_valid, s_data, mem_dout, tap_ready,
    input s_ready, mem_en, mem_addr, mem_din, tap_valid, tap_data, tap_idx, tap_last, busy
  );
endinterface

// File: rtl/dmem_agu.sv
// dmem_agu: circular-buffer AGU writing samples into datamem and sweeping taps newest-to-oldest.
// Define DMEM_AGU_CLEAR_EN to zero-fill the delay line after every reset.
module dmem_agu #(
  parameter logic [7:0] BUF_BASE = 8'h00,
  parameter int BUF_LEN = 16
) (
  input logic clk,
  input logic rst_n,
  dmem_agu_if.slave bus
);
  localparam logic [7:0] LAST = 8'(BUF_LEN - 1);
  localparam logic [8:0] LEN9 = 9'(BUF_LEN);
  typedef enum logic [2:0] {CLEAR, IDLE, WR, RD, OUT} state_t;
`ifdef DMEM_AGU_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, state_d;
  logic [7:0] wptr, wptr_d, newest, newest_d, k, k_d, addr_d, idx_d, prev;
  logic [15:0] din_d, data_d;
  logic en_d, valid_d, last_d;
  logic [8:0] back;
  // index of the next-older tap, wrapped back into 0..BUF_LEN-1
  assign back = {1'b0, newest} - {1'b0, k} - 9'd1;
  assign prev = back[8] ? 8'(back + LEN9) : back[7:0];
  assign bus.s_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_d = state;
    wptr_d = wptr;
    newest_d = newest;
    k_d = k;
    en_d = bus.mem_en;
    addr_d = bus.mem_addr;
    din_d = bus.mem_din;
    valid_d = bus.tap_valid;
    data_d = bus.tap_data;
    idx_d = bus.tap_idx;
    last_d = bus.tap_last;
    case (state)
`ifdef DMEM_AGU_CLEAR_EN
      CLEAR: begin
        en_d = 1'b1;
        addr_d = bus.mem_en ? bus.mem_addr + 8'd1 : BUF_BASE;
        if (bus.mem_en && bus.mem_addr == BUF_BASE + LAST) begin
          en_d = 1'b0;
          addr_d = BUF_BASE;
          state_d = IDLE;
        end
      end
`endif
      IDLE: if (bus.s_valid) begin
        din_d = bus.s_data;
        addr_d = BUF_BASE + wptr;
        en_d = 1'b1;
        state_d = WR;
      end
      WR: begin
        newest_d = wptr;
        k_d = 8'd0;
        wptr_d = wptr == LAST ? 8'd0 : wptr + 8'd1;
        en_d = 1'b0;
        addr_d = BUF_BASE + wptr;
        state_d = RD;
      end
      RD: begin
        data_d = bus.mem_dout;
        idx_d = k;
        last_d = k == LAST;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: if (bus.tap_ready) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        state_d = bus.tap_last ? IDLE : RD;
        k_d = bus.tap_last ? k : k + 8'd1;
        addr_d = bus.tap_last ? bus.mem_addr : BUF_BASE + prev;
      end
      default: state_d = RST_STATE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      wptr <= 8'd0;
      newest <= 8'd0;
      k <= 8'd0;
      bus.mem_en <= 1'b0;
      bus.mem_addr <= BUF_BASE;
      bus.mem_din <= 16'd0;
      bus.tap_valid <= 1'b0;
      bus.tap_data <= 16'd0;
      bus.tap_idx <= 8'd0;
      bus.tap_last <= 1'b0;
    end else begin
      state <= state_d;
      wptr <= wptr_d;
      newest <= newest_d;
      k <= k_d;
      bus.mem_en <= en_d;
      bus.mem_addr <= addr_d;
      bus.mem_din <= din_d;
      bus.tap_valid <= valid_d;
      bus.tap_data <= data_d;
      bus.tap_idx <= idx_d;
      bus.tap_last <= last_d;
    end
  end
endmodule
